// File: rtl/plateau_detector_if.sv
// ----------------------------------------------------------------------------
// plateau_detector_if : sample stream in, detection status out.
// Optional member det_count exists only when PLATEAU_DET_CNT_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface plateau_detector_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] corr_in;
  logic signed [DATA_WIDTH-1:0] power_in;
  logic                         data_in_valid;
  logic                         pkt_detect;
  logic                         pkt_active;
  logic [1:0]                   state_out;
`ifdef PLATEAU_DET_CNT_EN
  logic [15:0]                  det_count;

  modport master (
    output corr_in, power_in, data_in_valid,
    input  pkt_detect, pkt_active, state_out, det_count
  );
  modport slave (
    input  corr_in, power_in, data_in_valid,
    output pkt_detect, pkt_active, state_out, det_count
  );
`else
  modport master (
    output corr_in, power_in, data_in_valid,
    input  pkt_detect, pkt_active, state_out
  );
  modport slave (
    input  corr_in, power_in, data_in_valid,
    output pkt_detect, pkt_active, state_out
  );
`endif
endinterface

`default_nettype wire

// File: rtl/plateau_detector.sv
// ----------------------------------------------------------------------------
// plateau_detector : declares a packet after PLATEAU_LEN consecutive samples
// whose correlation/power ratio clears THRESH_Q/16, then holds off.
// Optional macro PLATEAU_DET_CNT_EN adds a 16-bit detection counter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plateau_detector #(
  parameter int DATA_WIDTH  = 32,
  parameter int THRESH_Q    = 12,
  parameter int PLATEAU_LEN = 16,
  parameter int HOLDOFF_LEN = 64,
  parameter int MIN_POWER   = 64
) (
  input  wire logic          clk_in,
  input  wire logic          rst_in,
  plateau_detector_if.slave  bus
);

  localparam int c_PW = DATA_WIDTH + 5;
  localparam logic signed [c_PW-1:0]       c_SIXTEEN   = c_PW'(16);
  localparam logic signed [c_PW-1:0]       c_THRESH    = c_PW'(THRESH_Q);
  localparam logic signed [DATA_WIDTH-1:0] c_MIN_POWER = DATA_WIDTH'(MIN_POWER);
  localparam logic [7:0]                   c_PLAT_LEN  = 8'(PLATEAU_LEN);
  localparam logic [15:0]                  c_HOLD_INIT = 16'(HOLDOFF_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNT    = 2'd1,
    S_DETECTED = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_run;
  logic [15:0] r_hold;
  logic        r_detect;
  logic        r_active;

  // Products are widened by 5 bits so neither side can overflow.
  logic signed [c_PW-1:0] w_corr_ext;
  logic signed [c_PW-1:0] w_power_ext;
  logic signed [c_PW-1:0] w_corr_scaled;
  logic signed [c_PW-1:0] w_power_scaled;
  logic                   w_hit;
  logic [7:0]             w_run_inc;

  assign w_corr_ext     = {{5{bus.corr_in[DATA_WIDTH-1]}}, bus.corr_in};
  assign w_power_ext    = {{5{bus.power_in[DATA_WIDTH-1]}}, bus.power_in};
  assign w_corr_scaled  = w_corr_ext * c_SIXTEEN;
  assign w_power_scaled = w_power_ext * c_THRESH;

  assign w_hit = bus.data_in_valid
              && !bus.corr_in[DATA_WIDTH-1] && (bus.corr_in != '0)
              && (bus.power_in >= c_MIN_POWER)
              && (w_corr_scaled >= w_power_scaled);

  assign w_run_inc = (r_run == 8'hFF) ? 8'hFF : r_run + 8'd1;

`ifdef PLATEAU_DET_CNT_EN
  logic [15:0] r_det_count;
  assign bus.det_count = r_det_count;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_run    <= 8'd0;
      r_hold   <= 16'd0;
      r_detect <= 1'b0;
      r_active <= 1'b0;
`ifdef PLATEAU_DET_CNT_EN
      r_det_count <= 16'd0;
`endif
    end else begin
      r_detect <= 1'b0;
      if (bus.data_in_valid) begin
        case (r_state)
          S_IDLE: begin
            if (w_hit) begin
              r_run <= 8'd1;
              if (c_PLAT_LEN == 8'd1) begin
                r_state  <= S_DETECTED;
                r_active <= 1'b1;
                r_detect <= 1'b1;
`ifdef PLATEAU_DET_CNT_EN
                r_det_count <= r_det_count + 16'd1;
`endif
              end else begin
                r_state <= S_COUNT;
              end
            end
          end
          S_COUNT: begin
            if (w_hit) begin
              r_run <= w_run_inc;
              if (w_run_inc == c_PLAT_LEN) begin
                r_state  <= S_DETECTED;
                r_active <= 1'b1;
                r_detect <= 1'b1;
`ifdef PLATEAU_DET_CNT_EN
                r_det_count <= r_det_count + 16'd1;
`endif
              end
            end else begin
              r_state <= S_IDLE;
              r_run   <= 8'd0;
            end
          end
          S_DETECTED: begin
            if (!w_hit) begin
              r_state  <= S_HOLDOFF;
              r_active <= 1'b0;
              r_hold   <= c_HOLD_INIT;
            end
          end
          S_HOLDOFF: begin
            // Samples here are consumed unconditionally, never treated as hits.
            if (r_hold == 16'd0) begin
              r_state <= S_IDLE;
              r_run   <= 8'd0;
            end else begin
              r_hold <= r_hold - 16'd1;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pkt_detect = r_detect;
  assign bus.pkt_active = r_active;
  assign bus.state_out  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_plateau_detector.sv
// ----------------------------------------------------------------------------
// tb_plateau_detector : table vectors plus corner sequences, scoreboarded
// against a small behavioural model of the detector.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_plateau_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  plateau_detector_if #(.DATA_WIDTH(32)) bus ();

  plateau_detector dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    bit        det;
    bit        act;
    bit [1:0]  st;
    bit [15:0] cnt;
    string     name;
  } exp_t;

  typedef struct {
    bit       v;
    int       corr;
    int       power;
    bit       det;
    bit       act;
    bit [1:0] st;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[19];
  int   n_vec  = 0;
  int   n_fail = 0;

  int        m_state = 0;
  int        m_run   = 0;
  int        m_hold  = 0;
  bit [15:0] m_cnt   = 16'd0;

  function automatic bit model_hit(bit v, int c, int p);
    longint lc = c;
    longint lp = p;
    return v && (lc > 0) && (lp >= 64) && (lc * 16 >= lp * 12);
  endfunction

  task automatic model_step(input bit v, input int c, input int p,
                            input string name, output exp_t e);
    bit h;
    e.det = 1'b0;
    h = model_hit(v, c, p);
    if (v) begin
      if (m_state == 0) begin
        if (h) begin m_state = 1; m_run = 1; end
      end else if (m_state == 1) begin
        if (!h) begin m_state = 0; m_run = 0; end
        else begin
          m_run++;
          if (m_run == 16) begin m_state = 2; e.det = 1'b1; m_cnt++; end
        end
      end else if (m_state == 2) begin
        if (!h) begin m_state = 3; m_hold = 63; end
      end else begin
        if (m_hold == 0) m_state = 0;
        else m_hold--;
      end
    end
    e.act  = (m_state == 2);
    e.st   = 2'(m_state);
    e.cnt  = m_cnt;
    e.name = name;
  endtask

  task automatic check(input exp_t e);
    bit [15:0] got_cnt;
    got_cnt = e.cnt;
`ifdef PLATEAU_DET_CNT_EN
    got_cnt = bus.det_count;
`endif
    n_vec++;
    if ({bus.pkt_detect, bus.pkt_active, bus.state_out, got_cnt} !== {e.det, e.act, e.st, e.cnt}) begin
      n_fail++;
      $display("FAIL %s: got det=%0b act=%0b st=%0d cnt=%0d, want det=%0b act=%0b st=%0d cnt=%0d",
               e.name, bus.pkt_detect, bus.pkt_active, bus.state_out, got_cnt,
               e.det, e.act, e.st, e.cnt);
    end
  endtask

  task automatic drive(input bit v, input int c, input int p, input exp_t e);
    exp_t got;
    @(negedge clk);
    bus.data_in_valid = v;
    bus.corr_in       = c;
    bus.power_in      = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      got = sb.pop_front();
      check(got);
    end
  endtask

  task automatic step(input bit v, input int c, input int p, input string name);
    exp_t e;
    model_step(v, c, p, name, e);
    drive(v, c, p, e);
  endtask

  task automatic do_reset(input string name);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    bus.data_in_valid = 1'b1;
    bus.corr_in  = 100;
    bus.power_in = 120;
    @(posedge clk);
    #1;
    m_state = 0; m_run = 0; m_hold = 0; m_cnt = 16'd0;
    e.det = 1'b0; e.act = 1'b0; e.st = 2'd0; e.cnt = 16'd0; e.name = name;
    check(e);
    @(negedge clk);
    rst = 1'b0;
    bus.data_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bus.data_in_valid = 1'b0;
    bus.corr_in  = 0;
    bus.power_in = 0;

    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 100, 120, (i == 15), (i == 15), (i == 15) ? 2'd2 : 2'd1};
    tbl[16] = '{1'b1, 100, 120, 1'b0, 1'b1, 2'd2};
    tbl[17] = '{1'b0,  80, 120, 1'b0, 1'b1, 2'd2};
    tbl[18] = '{1'b1,  80, 120, 1'b0, 1'b0, 2'd3};

    do_reset("reset_initial");

    // Table: 16 hits to detect, stay, gap, miss into holdoff.
    for (int i = 0; i < 19; i++) begin
      exp_t m;
      model_step(tbl[i].v, tbl[i].corr, tbl[i].power, "table", m);
      e = m;
      e.det = tbl[i].det; e.act = tbl[i].act; e.st = tbl[i].st;
      e.name = $sformatf("table[%0d]", i);
      drive(tbl[i].v, tbl[i].corr, tbl[i].power, e);
    end

    // 64 hits are swallowed by holdoff, then a fresh plateau detects again.
    for (int i = 0; i < 64; i++) step(1'b1, 100, 120, "holdoff_hits");
    for (int i = 0; i < 16; i++) step(1'b1, 100, 120, "redetect");

    do_reset("reset_after_detect");
    for (int i = 0; i < 15; i++) step(1'b1, 100, 120, "run15");
    step(1'b1, 80, 120, "miss_breaks_run");
    for (int i = 0; i < 16; i++) step(1'b1, 100, 120, "run16_after_miss");

    do_reset("reset_gate");
    for (int i = 0; i < 4; i++) step(1'b1, 100, 50, "low_power");
    for (int i = 0; i < 4; i++) step(1'b1, -5, 120, "neg_corr");
    step(1'b1, 100, 63, "power_63");
    step(1'b1, 0, 100, "corr_zero");
    step(1'b1, 100, -100, "neg_power");
    step(1'b1, 74, 100, "ratio_below");
    step(1'b1, 75, 100, "ratio_equal");
    step(1'b1, 48, 64, "min_power_equal");
    step(1'b1, 2147483647, 2147483647, "wide_product");
    step(1'b1, 1000, 2147483647, "wide_miss");

    do_reset("reset_gaps");
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 100, 120, "gapped_hit");
      for (int g = 0; g < 3; g++) step(1'b0, 100, 120, "gap");
    end

    do_reset("reset_mid_detected");
    for (int i = 0; i < 10; i++) step(1'b1, 100, 120, "pre_reset_hits");
    do_reset("reset_mid_count");
    for (int i = 0; i < 6; i++) step(1'b1, 100, 120, "post_reset_hits");
    for (int i = 0; i < 10; i++) step(1'b1, 100, 120, "complete_plateau");
    step(1'b1, 80, 120, "enter_holdoff");
    for (int i = 0; i < 5; i++) step(1'b1, 100, 120, "holdoff_partial");
    do_reset("reset_mid_holdoff");
    step(1'b1, 100, 120, "first_after_holdoff_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/plateau_detector.md
PLATEAU_DETECTOR -- requirements
Module: plateau_detector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the averaged correlation and power inputs.
REQ-002 SHALL have parameter THRESH_Q, default 12: detection ratio numerator in Q4 (12 = 0.75), legal range 1..16.
REQ-003 SHALL have parameter PLATEAU_LEN, default 16: consecutive hit samples required to declare a packet, legal range 1..255.
REQ-004 SHALL have parameter HOLDOFF_LEN, default 64: valid samples ignored after the plateau ends, legal range 1..65535.
REQ-005 SHALL have parameter MIN_POWER, default 64: minimum power_in for a sample to count as a hit.
REQ-006 clk_in  input  1  single clock; all logic on its rising edge.
REQ-007 rst_in  input  1  reset; synchronous, active-high.
REQ-008 corr_in  input  DATA_WIDTH signed  moving-averaged autocorrelation magnitude.
REQ-009 power_in  input  DATA_WIDTH signed  moving-averaged signal power.
REQ-010 data_in_valid  input  1  corr_in and power_in qualify this cycle.
REQ-011 pkt_detect  output  1  single-cycle pulse on packet start.
REQ-012 pkt_active  output  1  high while in DETECTED.
REQ-013 state_out  output  2  current FSM state: IDLE=0, COUNT=1, DETECTED=2, HOLDOFF=3.

Function
REQ-014 hit SHALL be true iff data_in_valid, corr_in > 0, power_in >= MIN_POWER, and corr_in*16 >= power_in*THRESH_Q.
REQ-015 Both products SHALL be computed signed at DATA_WIDTH+5 bits, with no overflow or truncation.
REQ-016 On cycles with data_in_valid=0: state and counters SHALL hold, and pkt_detect SHALL be 0.
REQ-017 IDLE: hit with PLATEAU_LEN=1 -> DETECTED; any other hit -> COUNT with run count=1; miss -> stay.
REQ-018 COUNT: hit increments run count; when the incremented count equals PLATEAU_LEN -> DETECTED; miss -> IDLE with run count=0.
REQ-019 pkt_detect SHALL be registered high for exactly the cycle after the sample that causes entry to DETECTED.
REQ-020 DETECTED: hit -> stay, with no further pulse; miss -> HOLDOFF with holdoff count=HOLDOFF_LEN-1.
REQ-021 HOLDOFF: each valid sample (hit or miss) decrements holdoff count; a valid sample at count 0 -> IDLE, and that sample is not evaluated as a hit.
REQ-022 pkt_active SHALL be high exactly while state_out==2, with registered timing identical to state_out.
REQ-023 Run count SHALL be 8 bits and saturate, never wrapping; the holdoff counter SHALL be 16 bits.
REQ-024 Output latency SHALL be one clock from the qualifying input sample; no back-pressure exists.

Reset
REQ-025 rst_in high at any clock edge SHALL force state IDLE, all counters 0, pkt_detect=0, pkt_active=0, and state_out=0, overriding data_in_valid.
REQ-026 Reset asserted mid-COUNT, mid-DETECTED or mid-HOLDOFF SHALL discard progress, and the first valid sample after release SHALL be evaluated from IDLE.
REQ-027 Any optional counter SHALL also clear to 0 on reset.

Configuration
REQ-028 Macro PLATEAU_DET_CNT_EN defined: the block SHALL add output det_count (16 bits) counting pkt_detect pulses, wrapping 0xFFFF->0, updated on the pulse cycle.
REQ-029 Macro PLATEAU_DET_CNT_EN undefined: port det_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Defaults; reset; 16 consecutive valid samples with corr=100, power=120 (100*16=1600 >= 1440) -> pkt_detect pulses once, one cycle after sample 16; pkt_active high from then.
REQ-031 15 hits then corr=80, power=120 (1280 < 1440), then 16 hits -> state returns to IDLE after the miss; exactly one pulse, after the final 16th hit.
REQ-032 Hits with power=50 (< MIN_POWER) or corr=-5 -> no state change from IDLE; pkt_detect stays 0.
REQ-033 From DETECTED, one miss then 64 valid hits -> state HOLDOFF for those 64 samples, IDLE after the 64th, no pulse; 16 further hits -> new pulse.
REQ-034 Valid samples interleaved with invalid gaps of 3 cycles -> same detection sample index as the gapless case; pkt_detect is never high on a gap cycle.
REQ-035 Reset asserted after 10 hits, then 6 hits -> no pulse; with PLATEAU_DET_CNT_EN defined, det_count reads 0 after reset and 1 after a subsequent detection.
